// File: rtl/fetch_queue.sv
// fetch_queue: flushable FIFO between the fetch and decode stages.
// Buffers {pc, inst} bundles behind valid/allowin handshakes on both sides.
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 64,
  parameter bit FULL_PASS = 1'b1,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [DATA_W-1:0] in_bus,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [DATA_W-1:0] out_bus,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  max_count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_nxt;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign out_valid = ~empty & ~flush;
  assign out_bus   = mem[rd_ptr];

  // Pass mode lets a full queue accept when the head leaves this cycle.
  if (FULL_PASS) begin : g_pass
    assign in_allowin = ~full | out_allowin;
  end else begin : g_nopass
    assign in_allowin = ~full;
  end

  assign push = in_valid & in_allowin & ~flush;
  assign pop  = out_valid & out_allowin;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // High-water mark survives flushes; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      max_count <= '0;
    end else begin
      count <= count_nxt;
      if (count_nxt > max_count)
        max_count <= count_nxt;
    end
  end

endmodule
